// File: rtl/stopwatch_pkg.sv
// Shared encodings and constants for the stopwatch controller and its BCD counter.
package stopwatch_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_NINE = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_e;

endpackage

// File: rtl/bcd_counter.sv
// N-digit BCD up-counter with synchronous clear and ripple carry between digits.
module bcd_counter
  import stopwatch_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clr,
  input  logic                      inc,
  output logic [DIGIT_W*DIGITS-1:0] value,
  output logic                      all_nines
);

  logic [DIGIT_W*DIGITS-1:0] value_q, value_d;
  logic                      carry;

  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    value_d   = value_q;
    carry     = inc;
    all_nines = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (value_q[i*DIGIT_W +: DIGIT_W] != BCD_NINE) all_nines = 1'b0;
      if (carry) begin
        if (value_q[i*DIGIT_W +: DIGIT_W] == BCD_NINE) begin
          value_d[i*DIGIT_W +: DIGIT_W] = '0;
        end else begin
          value_d[i*DIGIT_W +: DIGIT_W] = value_q[i*DIGIT_W +: DIGIT_W] + DIGIT_W'(1);
          carry = 1'b0;
        end
      end
    end
    if (clr) value_d = '0;
  end

  // NOTE: state registers use non-blocking assignments only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) value_q <= '0;
    else       value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// Stopwatch controller: button edge detect, start/pause/lap FSM, tick prescaler,
// BCD elapsed count with wrap or saturate policy, and lap display freeze.
module stopwatch_lap_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 100000,
  parameter int WRAP     = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start_btn,
  input  logic                      stop_btn,
  input  logic                      lap_btn,
  output logic [DIGIT_W*DIGITS-1:0] count,
  output logic [DIGIT_W*DIGITS-1:0] disp,
  output logic [1:0]                state,
  output logic                      overflow
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  state_e                    state_q;
  logic [PW-1:0]             presc_q;
  logic [DIGIT_W*DIGITS-1:0] lap_q;
  logic                      overflow_q;
  logic                      start_q, stop_q, lap_q_btn;

  logic start_pe, stop_pe, lap_pe;
  logic active, tick, all_nines, saturate, inc_en;

  assign start_pe = start_btn & ~start_q;
  assign stop_pe  = stop_btn  & ~stop_q;
  assign lap_pe   = lap_btn   & ~lap_q_btn;

  assign active   = (state_q == RUN) || (state_q == LAP);
  assign tick     = active && (presc_q == PW'(TICK_DIV - 1));
  assign saturate = (WRAP == 0) && all_nines;
  // A stop edge wins over a due increment; saturation holds the all-9s value.
  assign inc_en   = tick && !stop_pe && !saturate;

  bcd_counter #(.DIGITS(DIGITS)) u_count (
    .clk       (clk),
    .reset     (reset),
    .clr       (stop_pe),
    .inc       (inc_en),
    .value     (count),
    .all_nines (all_nines)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      lap_q      <= '0;
      overflow_q <= 1'b0;
      // Histories start high so a button held through reset release is not an edge.
      start_q    <= 1'b1;
      stop_q     <= 1'b1;
      lap_q_btn  <= 1'b1;
    end else begin
      start_q    <= start_btn;
      stop_q     <= stop_btn;
      lap_q_btn  <= lap_btn;
      overflow_q <= 1'b0;
      if (stop_pe) begin
        state_q <= IDLE;
        presc_q <= '0;
        lap_q   <= '0;
      end else begin
        if (active) presc_q <= tick ? '0 : presc_q + PW'(1);
        if (tick && all_nines) overflow_q <= 1'b1;
        if (start_pe) begin
          case (state_q)
            IDLE:    state_q <= RUN;
            RUN:     state_q <= PAUSE;
            PAUSE:   state_q <= RUN;
            default: state_q <= PAUSE;
          endcase
        end else if (lap_pe) begin
          if (state_q == RUN) begin
            lap_q   <= count;
            state_q <= LAP;
          end else if (state_q == LAP) begin
            state_q <= RUN;
          end
        end
        // Auto-pause on saturation overrides any same-cycle transition.
        if (tick && saturate) state_q <= PAUSE;
      end
    end
  end

  assign state    = state_q;
  assign overflow = overflow_q;
  assign disp     = (state_q == LAP) ? lap_q : count;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// Directed bench for stopwatch_lap_ctrl (DIGITS=2, TICK_DIV=4): a wrapping and a
// saturating instance share the same button stimulus.
module tb_stopwatch_lap_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_btn = 1'b0, stop_btn = 1'b0, lap_btn = 1'b0;
  logic [7:0] count, disp, count_s, disp_s;
  logic [1:0] state, state_s;
  logic       overflow, overflow_s;

  int tests_run = 0;
  int failures  = 0;

  always #5 clk = ~clk;

  stopwatch_lap_ctrl #(.DIGITS(2), .TICK_DIV(4), .WRAP(1)) dut (
    .clk(clk), .reset(reset), .start_btn(start_btn), .stop_btn(stop_btn),
    .lap_btn(lap_btn), .count(count), .disp(disp), .state(state), .overflow(overflow)
  );

  stopwatch_lap_ctrl #(.DIGITS(2), .TICK_DIV(4), .WRAP(0)) dut_sat (
    .clk(clk), .reset(reset), .start_btn(start_btn), .stop_btn(stop_btn),
    .lap_btn(lap_btn), .count(count_s), .disp(disp_s), .state(state_s), .overflow(overflow_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Hold the given buttons high for exactly one rising clock edge.
  task automatic pulse(input logic s, input logic p, input logic l);
    start_btn = s; stop_btn = p; lap_btn = l;
    @(negedge clk);
    start_btn = 1'b0; stop_btn = 1'b0; lap_btn = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    check("rst_state", state, 2'b00);
    check("rst_count", count, 8'h00);
    check("rst_disp", disp, 8'h00);
    check("rst_ovf", overflow, 1'b0);
    reset = 1'b0;
    cycles(2);
    check("idle_hold", state, 2'b00);

    // Start, then first two ticks.
    pulse(1, 0, 0);
    check("t1_state_run", state, 2'b01);
    check("t1_count0", count, 8'h00);
    cycles(3);
    check("t1_pre_tick", count, 8'h00);
    cycles(1);
    check("t1_count1", count, 8'h01);
    cycles(4);
    check("t1_count2", count, 8'h02);
    check("t1_no_ovf", overflow, 1'b0);

    // Pause with prescaler at 2; the pause edge advances it to 3 and resume keeps it.
    cycles(6);
    check("t2_count3", count, 8'h03);
    pulse(1, 0, 0);
    check("t2_pause", state, 2'b10);
    cycles(20);
    check("t2_hold_cnt", count, 8'h03);
    check("t2_hold_st", state, 2'b10);
    pulse(1, 0, 0);
    check("t2_resume", state, 2'b01);
    check("t2_resume_cnt", count, 8'h03);
    cycles(1);
    check("t2_phase", count, 8'h04);

    // Lap freeze at 05 while count runs on.
    cycles(4);
    check("t3_count5", count, 8'h05);
    pulse(0, 0, 1);
    check("t3_lap_state", state, 2'b11);
    check("t3_lap_disp", disp, 8'h05);
    cycles(3);
    check("t3_count6", count, 8'h06);
    check("t3_disp_frz6", disp, 8'h05);
    cycles(4);
    check("t3_count7", count, 8'h07);
    check("t3_disp_frz7", disp, 8'h05);
    pulse(0, 0, 1);
    check("t3_release", state, 2'b01);
    check("t3_disp_live", disp, 8'h07);

    // Start and stop together: stop wins; then lap in IDLE is ignored.
    cycles(19);
    check("t5_count12", count, 8'h12);
    pulse(1, 1, 0);
    check("t5_state", state, 2'b00);
    check("t5_count", count, 8'h00);
    check("t5_disp", disp, 8'h00);
    pulse(0, 0, 1);
    cycles(2);
    check("t5_lap_idle", state, 2'b00);
    check("t5_lap_cnt", count, 8'h00);

    // Run to 99 and over: wrap on one instance, saturate on the other.
    pulse(1, 0, 0);
    cycles(396);
    check("t4_count99", count, 8'h99);
    cycles(3);
    check("t4_pre_ovf", overflow, 1'b0);
    check("t4_pre_cnt", count, 8'h99);
    cycles(1);
    check("t4w_count", count, 8'h00);
    check("t4w_ovf", overflow, 1'b1);
    check("t4w_state", state, 2'b01);
    check("t4s_count", count_s, 8'h99);
    check("t4s_ovf", overflow_s, 1'b1);
    check("t4s_state", state_s, 2'b10);
    cycles(1);
    check("t4w_ovf_drop", overflow, 1'b0);
    check("t4s_ovf_drop", overflow_s, 1'b0);
    check("t4w_cnt_hold", count, 8'h00);

    // Saturated instance resumes and re-pauses at the next tick.
    pulse(1, 0, 0);
    check("t4s_resume", state_s, 2'b01);
    check("t4w_paused", state, 2'b10);
    cycles(3);
    check("t4s_pre_ovf2", overflow_s, 1'b0);
    cycles(1);
    check("t4s_ovf2", overflow_s, 1'b1);
    check("t4s_repause", state_s, 2'b10);
    check("t4s_cnt_sat", count_s, 8'h99);

    // Asynchronous reset mid-run with start held through release.
    pulse(1, 0, 0);
    check("t6_run", state, 2'b01);
    cycles(4);
    check("t6_pre_cnt", count, 8'h01);
    #2;
    start_btn = 1'b1;
    reset = 1'b1;
    #1;
    check("t6_async_cnt", count, 8'h00);
    check("t6_async_st", state, 2'b00);
    @(negedge clk);
    reset = 1'b0;
    cycles(3);
    check("t6_held_idle", state, 2'b00);
    start_btn = 1'b0;
    cycles(1);
    start_btn = 1'b1;
    cycles(1);
    check("t6_repress", state, 2'b01);
    start_btn = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
